// File: rtl/sev_seg_scan_ctrl_if.sv
// Bus bundle for the seven-segment scan controller: display data in, drive pins out.
interface sev_seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic [7:0]              sev_seg_leds;
    logic [NUM_DIGITS-1:0]   led_enable;
    logic                    frame_tick;

    modport master (
        output digits, dp_in, digit_en, lz_blank,
        input  sev_seg_leds, led_enable, frame_tick
    );

    modport slave (
        input  digits, dp_in, digit_en, lz_blank,
        output sev_seg_leds, led_enable, frame_tick
    );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-frame shadowing of display
// data, anti-ghosting guard cycles, per-digit enable and leading-zero blanking.
module sev_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    sev_seg_scan_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DW = 4 * NUM_DIGITS;

    // Scan state
    logic [PW-1:0]         r_pcnt;
    logic [IW-1:0]         r_idx;

    // Shadow copies, refreshed once per frame
    logic [DW-1:0]         r_sh_digits;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_en;
    logic                  r_sh_lz;

    // Registered outputs
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_en;
    logic                  r_tick;

    // Combinational next-state / output terms
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_load;
    logic [PW-1:0]         w_pcnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [NUM_DIGITS-1:0] w_lz_dark;
    logic                  w_zero_run;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_on;
    logic                  w_guard;
    logic [7:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Prescaler and digit-index next state; shadow load at the last cycle of a frame
    always_comb begin
        w_slot_end  = (r_pcnt == PW'(REFRESH_DIV - 1));
        w_frame_end = (r_idx == IW'(NUM_DIGITS - 1));
        w_load      = w_slot_end && w_frame_end;
        w_pcnt_nxt  = r_pcnt + PW'(1);
        w_idx_nxt   = r_idx;
        if (w_slot_end) begin
            w_pcnt_nxt = '0;
            w_idx_nxt  = w_frame_end ? '0 : r_idx + IW'(1);
        end
    end

    // Leading-zero blanking: digit k dark when it and everything above it is zero
    always_comb begin
        w_lz_dark  = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_sh_digits[4*k +: 4] == 4'h0);
            if (k > 0) begin
                w_lz_dark[k] = r_sh_lz && w_zero_run && !r_sh_dp[k];
            end
        end
    end

    // Select the active digit and form the next segment / anode drive
    always_comb begin
        w_nib     = '0;
        w_dp      = 1'b0;
        w_on      = 1'b0;
        w_en_nxt  = '1;
        w_seg_nxt = 8'hFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib = r_sh_digits[4*k +: 4];
                w_dp  = r_sh_dp[k];
                w_on  = r_sh_en[k] && !w_lz_dark[k];
            end
        end
        w_guard = (r_pcnt < PW'(BLANK_CYCLES));
        if (!w_guard && w_on) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                w_en_nxt[k] = (r_idx != IW'(k));
            end
            w_seg_nxt = {~w_dp, hex7(w_nib)};
        end
    end

    // State, shadow and output registers; reset reloads shadows from the live inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt      <= '0;
            r_idx       <= '0;
            r_sh_digits <= bus.digits;
            r_sh_dp     <= bus.dp_in;
            r_sh_en     <= bus.digit_en;
            r_sh_lz     <= bus.lz_blank;
            r_seg       <= 8'hFF;
            r_en        <= '1;
            r_tick      <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
            r_idx  <= w_idx_nxt;
            if (w_load) begin
                r_sh_digits <= bus.digits;
                r_sh_dp     <= bus.dp_in;
                r_sh_en     <= bus.digit_en;
                r_sh_lz     <= bus.lz_blank;
            end
            r_seg  <= w_seg_nxt;
            r_en   <= w_en_nxt;
            r_tick <= w_load;
        end
    end

    assign bus.sev_seg_leds = r_seg;
    assign bus.led_enable   = r_en;
    assign bus.frame_tick   = r_tick;
endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Scoreboard bench for sev_seg_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
module tb_sev_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t e_mon;

    sev_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] en, input logic [7:0] seg, input logic tick);
        exp_t e;
        e.cyc  = c;
        e.en   = en;
        e.seg  = seg;
        e.tick = tick;
        sb.push_back(e);
    endtask

    // Expected outputs for the first n cycles of a frame; slot s uses ens[4s+:4] / segs[8s+:8]
    task automatic push_frame(input int start, input int n, input logic [15:0] ens, input logic [31:0] segs);
        for (int t = 0; t < n; t++) begin
            int s;
            int p;
            s = t / RD;
            p = t % RD;
            if (p < BC)
                push(start + t, 4'hF, 8'hFF, 1'b0);
            else
                push(start + t, ens[4*s +: 4], segs[8*s +: 8], t == ND*RD - 1);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare each scheduled expectation on the falling edge of its cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e_mon = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_cyc%0d: expectation never compared (now cyc %0d)", e_mon.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e_mon = sb.pop_front();
            n_checks++;
            if (bus.led_enable !== e_mon.en || bus.sev_seg_leds !== e_mon.seg ||
                bus.frame_tick !== e_mon.tick) begin
                n_errors++;
                $display("FAIL cyc%0d: got en=%h seg=%h tick=%b, want en=%h seg=%h tick=%b",
                         cyc, bus.led_enable, bus.sev_seg_leds, bus.frame_tick,
                         e_mon.en, e_mon.seg, e_mon.tick);
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        bus.digits   = 16'h12AF;
        bus.digit_en = 4'hF;
        bus.dp_in    = 4'h0;
        bus.lz_blank = 1'b0;
        reset        = 1'b1;
        for (int c = 1; c <= 3; c++) push(c, 4'hF, 8'hFF, 1'b0);
        // Frame 1 (cycles 4..35): 1 2 A F, rightmost first
        push_frame(4, 32, 16'h7BDE, {8'hF9, 8'hA4, 8'h88, 8'h8E});
        goto(3);
        reset = 1'b0;

        // Leading-zero blanking of 0050
        goto(14);
        bus.digits   = 16'h0050;
        bus.lz_blank = 1'b1;
        push_frame(36, 32, 16'hFFDE, {8'hFF, 8'hFF, 8'h92, 8'hC0});

        // Decimal point on digit 2 defeats its blanking
        goto(46);
        bus.dp_in = 4'b0100;
        push_frame(68, 32, 16'hFBDE, {8'hFF, 8'h40, 8'h92, 8'hC0});

        // 1111, then change to 2222 mid slot 1: takes effect only next frame
        goto(78);
        bus.digits   = 16'h1111;
        bus.lz_blank = 1'b0;
        bus.dp_in    = 4'h0;
        push_frame(100, 32, 16'h7BDE, {8'hF9, 8'hF9, 8'hF9, 8'hF9});
        goto(111);
        bus.digits = 16'h2222;
        push_frame(132, 32, 16'h7BDE, {8'hA4, 8'hA4, 8'hA4, 8'hA4});

        // Digit 2 disabled for two frames, tick period checked every cycle
        goto(142);
        bus.digit_en = 4'b1011;
        push_frame(164, 32, 16'h7FDE, {8'hA4, 8'hFF, 8'hA4, 8'hA4});
        push_frame(196, 32, 16'h7FDE, {8'hA4, 8'hFF, 8'hA4, 8'hA4});

        // Re-enable; frame 8 is cut short by reset in slot 2 at pcnt 5
        goto(206);
        bus.digit_en = 4'hF;
        push_frame(228, 21, 16'h7BDE, {8'hA4, 8'hA4, 8'hA4, 8'hA4});

        goto(248);
        reset = 1'b1;
        push(249, 4'hF, 8'hFF, 1'b0);
        push_frame(250, 32, 16'h7BDE, {8'hA4, 8'hA4, 8'hA4, 8'hA4});
        goto(249);
        reset = 1'b0;

        goto(290);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL leftover: %0d expectations not compared, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sev_seg_scan_ctrl.md
SEV_SEG_SCAN_CTRL -- requirements
Module: sev_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-003 Parameter BLANK_CYCLES, default 4, anti-ghosting guard cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 digits  input  4*NUM_DIGITS  hex nibbles; nibble k = digits[4k+3:4k] drives digit k; digit 0 is rightmost.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit dark for its whole slot.
REQ-009 lz_blank  input  1  leading-zero suppression enable.
REQ-010 sev_seg_leds  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.
REQ-011 led_enable  output  NUM_DIGITS  active-low digit anodes; bit k selects digit k.
REQ-012 frame_tick  output  1  one-cycle pulse marking a shadow load / frame start.

Function
REQ-013 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx SHALL increment when pcnt = REFRESH_DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-014 Shadow registers for digits, dp_in, digit_en, lz_blank SHALL load only in the cycle where pcnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1, and in every reset cycle; input changes at other times SHALL NOT affect the display.
REQ-015 frame_tick SHALL be registered and high for exactly the one cycle following a non-reset shadow load; period = NUM_DIGITS*REFRESH_DIV cycles.
REQ-016 All outputs SHALL be registered, reflecting the (pcnt, idx, shadow) state of the previous cycle (latency 1 cycle).
REQ-017 Guard: when pcnt < BLANK_CYCLES, led_enable SHALL be all ones and sev_seg_leds 8'hFF.
REQ-018 Digit k is dark if shadow digit_en[k] = 0, or if LZ-blanked; a dark digit SHALL give led_enable all ones and sev_seg_leds 8'hFF for its whole slot.
REQ-019 LZ-blanked: shadow lz_blank = 1, k > 0, nibble k = 0, all nibbles above k = 0, and shadow dp_in[k] = 0; digit 0 SHALL never be LZ-blanked.
REQ-020 Otherwise led_enable SHALL equal all ones with bit idx cleared; sev_seg_leds[6:0] SHALL be the hex decode of nibble idx, bit 7 = ~dp_in[idx].
REQ-021 Hex decode (bit 7 = 1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E.
REQ-022 Counter widths SHALL be sized from parameters (ceil log2); no overflow for any legal parameter set.
REQ-023 With NUM_DIGITS = 1, idx SHALL stay 0 and a shadow load SHALL occur every REFRESH_DIV cycles.

Reset
REQ-024 In any cycle with reset = 1: pcnt <= 0, idx <= 0, shadows <= inputs, led_enable <= all ones, sev_seg_leds <= 8'hFF, frame_tick <= 0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL abort the scan; after release the scan SHALL restart at slot 0, pcnt 0, with no frame_tick until the first frame completes.
REQ-026 No output X after the first reset cycle.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 Hold reset 3 cycles -> led_enable=4'hF, sev_seg_leds=8'hFF, frame_tick=0 each cycle after first edge.
REQ-028 digits=16'h12AF, digit_en=4'hF, dp_in=0 -> slot0: 2 guard cycles of F/FF then 6 cycles led_enable=1110, segs=8E; slot1 1101/88; slot2 1011/A4; slot3 0111/F9; repeats.
REQ-029 digits=16'h0050, lz_blank=1 -> slots 3,2 dark (F/FF); slot1 1101/92; slot0 1110/C0; with dp_in=4'b0100 slot2 shows 1011/40.
REQ-030 Change digits 16'h1111 -> 16'h2222 in middle of slot1 -> display keeps '1' (F9) until the cycle after frame_tick, then '2' (A4).
REQ-031 Assert reset for 1 cycle during slot2, pcnt=5 -> next cycle all-off outputs; scan restarts slot0; first frame_tick 32 cycles after release.
REQ-032 digit_en=4'b1011 -> slot2 dark whole slot; frame_tick pulses every 32 cycles exactly.
